// File: rtl/fft_pwr_arbiter.sv
// fft_pwr_arbiter: frame-granular round-robin mux of FFT streams into one log-power pipeline
module fft_pwr_arbiter #(
  parameter int N_CH       = 4,
  parameter int CH_BITS    = 2,
  parameter int IN_WIDTH   = 22,
  parameter int USER_WIDTH = 1,
  parameter int LEN_BITS   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_CH*IN_WIDTH-1:0]      s_re,
  input  logic [N_CH*IN_WIDTH-1:0]      s_im,
  input  logic [N_CH*USER_WIDTH-1:0]    s_user,
  input  logic [N_CH-1:0]               s_valid,
  input  logic [N_CH-1:0]               s_last,
  output logic [N_CH-1:0]               s_ready,
  input  logic [N_CH-1:0]               ch_enable,
  input  logic [LEN_BITS-1:0]           max_len,
  output logic [IN_WIDTH-1:0]           m_re,
  output logic [IN_WIDTH-1:0]           m_im,
  output logic                          m_valid,
  output logic                          m_last,
  output logic [CH_BITS+USER_WIDTH-1:0] m_user,
  output logic                          busy,
  output logic [CH_BITS-1:0]            cur_ch,
  output logic [N_CH-1:0]               trunc_err,
  input  logic [N_CH-1:0]               err_clr
);
  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;
  state_t state;
  logic [LEN_BITS-1:0] cnt;
  logic [N_CH-1:0] req, tset;
  logic [CH_BITS-1:0] nxt;
  logic acc, lst, lim;
  assign req = s_valid & ch_enable;
  assign acc = (state != IDLE) && s_valid[cur_ch];
  assign lst = s_last[cur_ch];
  // >= rather than == so a limit lowered below the running count still cuts the next beat
  assign lim = (max_len != '0) && ((LEN_BITS+1)'(cnt) + 1'b1 >= (LEN_BITS+1)'(max_len));
  assign tset = (state == GRANT && acc && lim && !lst) ? N_CH'(1) << cur_ch : '0;
  assign s_ready = (state != IDLE) ? N_CH'(1) << cur_ch : '0;
  assign busy = state != IDLE;
  // descending scan so the nearest requester after cur_ch wins
  always_comb begin
    nxt = cur_ch;
    for (int i = N_CH; i >= 1; i--) begin
      if (req[CH_BITS'((int'(cur_ch) + i) % N_CH)]) nxt = CH_BITS'((int'(cur_ch) + i) % N_CH);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_ch    <= CH_BITS'(N_CH - 1);
      cnt       <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      m_re      <= '0;
      m_im      <= '0;
      m_user    <= '0;
      trunc_err <= '0;
    end else begin
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      trunc_err <= (trunc_err & ~err_clr) | tset;
      case (state)
        IDLE: if (|req) begin
          cur_ch <= nxt;
          state  <= GRANT;
        end
        GRANT: if (acc) begin
          m_valid <= 1'b1;
          m_last  <= lst | lim;
          m_re    <= s_re[int'(cur_ch)*IN_WIDTH +: IN_WIDTH];
          m_im    <= s_im[int'(cur_ch)*IN_WIDTH +: IN_WIDTH];
          m_user  <= {cur_ch, s_user[int'(cur_ch)*USER_WIDTH +: USER_WIDTH]};
          cnt     <= (lst | lim) ? '0 : cnt + 1'b1;
          state   <= lst ? IDLE : lim ? DRAIN : GRANT;
        end
        DRAIN: if (acc && lst) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_pwr_arbiter.sv
// tb_fft_pwr_arbiter: directed + randomized frame traffic checked against a frame-level round-robin model
module tb_fft_pwr_arbiter;
  localparam int N = 4, CB = 2, W = 22, UW = 1, LB = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic [N*W-1:0] s_re, s_im;
  logic [N*UW-1:0] s_user;
  logic [N-1:0] s_valid, s_last, s_ready, ch_enable, trunc_err, err_clr;
  logic [LB-1:0] max_len;
  logic [W-1:0] m_re, m_im;
  logic m_valid, m_last, busy;
  logic [CB+UW-1:0] m_user;
  logic [CB-1:0] cur_ch;
  always #5 clk = ~clk;
  fft_pwr_arbiter #(.N_CH(N), .CH_BITS(CB), .IN_WIDTH(W), .USER_WIDTH(UW), .LEN_BITS(LB)) dut (
    .clk(clk), .rst(rst), .s_re(s_re), .s_im(s_im), .s_user(s_user), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready), .ch_enable(ch_enable), .max_len(max_len),
    .m_re(m_re), .m_im(m_im), .m_valid(m_valid), .m_last(m_last), .m_user(m_user),
    .busy(busy), .cur_ch(cur_ch), .trunc_err(trunc_err), .err_clr(err_clr));
  typedef struct packed {logic [W-1:0] re; logic [W-1:0] im; logic last; logic [CB+UW-1:0] user;} beat_t;
  beat_t exp_q[$];
  int src_len[N][$], pend_len[N][$];
  int unsigned src_seed[N][$], pend_seed[N][$];
  int pos[N], stall_at[N], stall_n[N];
  int mv_cyc[$];
  logic [N-1:0] tr_exp = '0;
  int last_ch = N - 1, cyc = 0, prev_last = -1, v0 = 0, passes = 0, total = 0;
  bit gap_on = 1'b0, bubble_chk = 1'b0, rst_req = 1'b1;
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    total++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask
  function automatic beat_t mk(int c, int unsigned seed, int b, bit last);
    beat_t x;
    x.re = W'(seed + b);
    x.im = W'(seed ^ (b << 7));
    x.last = last;
    x.user = {CB'(c), 1'(seed >> (b % 32))};
    return x;
  endfunction
  task automatic add_frame(int c, int len);
    int unsigned seed;
    seed = $urandom;
    src_len[c].push_back(len);
    src_seed[c].push_back(seed);
    pend_len[c].push_back(len);
    pend_seed[c].push_back(seed);
  endtask
  // whole frames granted in round-robin order among enabled channels with pending frames
  task automatic schedule();
    int c, len, n;
    int unsigned seed;
    forever begin
      c = -1;
      for (int i = N; i >= 1; i--)
        if (ch_enable[(last_ch + i) % N] && pend_len[(last_ch + i) % N].size() > 0) c = (last_ch + i) % N;
      if (c < 0) break;
      len = pend_len[c].pop_front();
      seed = pend_seed[c].pop_front();
      n = (max_len != 0 && len > int'(max_len)) ? int'(max_len) : len;
      if (n < len) tr_exp[c] = 1'b1;
      for (int b = 0; b < n; b++) exp_q.push_back(mk(c, seed, b, b == n - 1));
      last_ch = c;
    end
  endtask
  function automatic bit pending();
    for (int c = 0; c < N; c++) if (src_len[c].size() > 0) return 1'b1;
    return 1'b0;
  endfunction
  task automatic drive();
    beat_t x;
    bit v;
    rst = rst_req;
    for (int c = 0; c < N; c++) begin
      v = 1'b0;
      x = '0;
      if (src_len[c].size() > 0) begin
        x = mk(c, src_seed[c][0], pos[c], pos[c] == src_len[c][0] - 1);
        if (pos[c] == stall_at[c] && stall_n[c] > 0) stall_n[c]--;
        else v = (pos[c] == 0) || !gap_on || ($urandom_range(3) != 0);
      end
      s_valid[c] = v;
      s_last[c] = x.last;
      s_re[c*W +: W] = x.re;
      s_im[c*W +: W] = x.im;
      s_user[c] = x.user[0];
    end
  endtask
  task automatic monitor();
    if (m_valid) begin
      mv_cyc.push_back(cyc);
      if (prev_last >= 0) begin
        if (bubble_chk) chk("frame_bubble", cyc - prev_last, 2);
        prev_last = -1;
      end
      chk("beat_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("beat", {m_re, m_im, m_last, m_user}, exp_q.pop_front());
      if (m_last) prev_last = cyc;
    end else chk("last_without_valid", m_last, 0);
  endtask
  task automatic step();
    logic [N-1:0] a;
    drive();
    #1 a = s_valid & s_ready;
    for (int c = 0; c < N; c++) if (a[c] && src_len[c].size() > 0) begin
      pos[c]++;
      if (pos[c] == src_len[c][0]) begin
        void'(src_len[c].pop_front());
        void'(src_seed[c].pop_front());
        pos[c] = 0;
      end
    end
    @(negedge clk);
    cyc++;
    monitor();
  endtask
  task automatic run_done(string tag, int budget);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || pending() || busy) && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_completes"}, n < budget, 1);
  endtask
  task automatic chk_reset(string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_m_data"}, {m_re, m_im, m_user}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cur_ch"}, cur_ch, N - 1);
    chk({tag, "_trunc_err"}, trunc_err, 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    ch_enable = '1;
    max_len = '0;
    err_clr = '0;
    for (int c = 0; c < N; c++) begin
      pos[c] = 0;
      stall_at[c] = -1;
      stall_n[c] = 0;
    end
    @(negedge clk);
    step();
    step();
    chk_reset("reset");
    rst_req = 1'b0;
    // single 8-beat frame on ch0, no length limit
    add_frame(0, 8);
    schedule();
    mv_cyc.delete();
    v0 = cyc;
    run_done("single", 100);
    chk("single_latency", mv_cyc[0] - v0, 2);
    chk("single_contiguous", mv_cyc[7] - mv_cyc[0], 7);
    chk("single_beats", mv_cyc.size(), 8);
    chk("single_idle", busy, 0);
    // ch1 and ch3 compete, order must alternate with one bubble between frames
    add_frame(1, 4);
    add_frame(1, 4);
    add_frame(3, 4);
    add_frame(3, 4);
    schedule();
    prev_last = -1;
    bubble_chk = 1'b1;
    run_done("rr", 200);
    bubble_chk = 1'b0;
    // ch0 stalls 3 cycles mid-frame while ch1 waits
    add_frame(0, 8);
    add_frame(1, 4);
    stall_at[0] = 3;
    stall_n[0] = 3;
    schedule();
    mv_cyc.delete();
    run_done("stall", 200);
    chk("stall_gap", mv_cyc[3] - mv_cyc[2], 4);
    chk("stall_prefix", mv_cyc[2] - mv_cyc[0], 2);
    stall_at[0] = -1;
    // truncation of a 9-beat frame at max_len=5
    max_len = 5;
    add_frame(2, 9);
    schedule();
    mv_cyc.delete();
    run_done("trunc", 200);
    chk("trunc_beats", mv_cyc.size(), 5);
    chk("trunc_err_set", trunc_err, tr_exp);
    err_clr = tr_exp;
    step();
    err_clr = '0;
    tr_exp = '0;
    chk("trunc_err_clear", trunc_err, tr_exp);
    max_len = '0;
    // disabled channel is never granted
    ch_enable = 4'b1110;
    add_frame(0, 3);
    repeat (4) step();
    chk("mask_s_ready", s_ready, 0);
    chk("mask_busy", busy, 0);
    ch_enable = '1;
    schedule();
    step();
    chk("mask_grant", busy, 1);
    run_done("mask", 100);
    // reset during the third beat of a ch1 frame
    add_frame(1, 8);
    add_frame(3, 4);
    schedule();
    for (int n = 0; n < 50 && pos[1] < 2; n++) step();
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    exp_q.delete();
    for (int c = 0; c < N; c++) begin
      src_len[c].delete();
      src_seed[c].delete();
      pend_len[c].delete();
      pend_seed[c].delete();
      pos[c] = 0;
    end
    last_ch = N - 1;
    tr_exp = '0;
    chk_reset("midrst");
    add_frame(3, 3);
    add_frame(2, 3);
    schedule();
    run_done("post_rst", 100);
    // randomized frames with mid-frame valid gaps and a length limit
    gap_on = 1'b1;
    max_len = 6;
    for (int c = 0; c < N; c++) for (int k = 0; k < 4; k++) add_frame(c, $urandom_range(1, 10));
    schedule();
    run_done("random", 3000);
    chk("random_trunc_err", trunc_err, tr_exp);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/fft_pwr_arbiter.md
Name: fft_pwr_arbiter

Overview:
- Frame-granular round-robin arbiter that shares one log-power pipeline (22-bit re/im in, 16-bit log power out, fixed latency, no backpressure) between N_CH FFT output streams.
- Grants whole frames delimited by last.
- Tags each beat with the source channel ID in the user field.
- Enforces a maximum frame length: an overlong frame is truncated, its tail is drained, and a per-channel sticky error is set.

Parameters:
- N_CH, 4, number of requesting FFT streams (2..16)
- CH_BITS, 2, channel-ID width; must equal clog2(N_CH)
- IN_WIDTH, 22, re/im sample width
- USER_WIDTH, 1, per-stream user sideband width
- LEN_BITS, 16, width of the frame-length limit and beat counter

Ports:
- clk  in  1  clock
- rst  in  1  reset
- s_re  in  N_CH*IN_WIDTH  per-channel real parts; channel k occupies [k*IN_WIDTH +: IN_WIDTH]
- s_im  in  N_CH*IN_WIDTH  per-channel imaginary parts, same packing
- s_user  in  N_CH*USER_WIDTH  per-channel user sideband
- s_valid  in  N_CH  per-channel beat valid
- s_last  in  N_CH  per-channel end of frame
- s_ready  out  N_CH  per-channel beat accepted
- ch_enable  in  N_CH  arbitration mask; 0 = channel never granted
- max_len  in  LEN_BITS  max beats per frame; 0 = no limit
- m_re  out  IN_WIDTH  to pipeline i_re
- m_im  out  IN_WIDTH  to pipeline i_im
- m_valid  out  1  to pipeline i_valid
- m_last  out  1  to pipeline i_last
- m_user  out  CH_BITS+USER_WIDTH  to pipeline i_user, {ch_id, user}
- busy  out  1  a frame is granted or draining
- cur_ch  out  CH_BITS  currently/last granted channel
- trunc_err  out  N_CH  sticky per-channel truncation flag
- err_clr  in  N_CH  write-1-to-clear for trunc_err

Behaviour:
- Reset: synchronous, active-high; clock clk.
- Reset values:
  - state=IDLE; s_ready=0; m_valid=0; m_last=0; m_re/m_im/m_user=0
  - busy=0; trunc_err=0; beat counter=0
  - cur_ch=N_CH-1, so channel 0 has priority after reset
- Reset asserted mid-frame aborts the frame immediately with no closing last emitted. The downstream pipeline is reset by the same rst.
- States: IDLE, GRANT, DRAIN.
- IDLE:
  - req = s_valid & ch_enable.
  - If req≠0, select the first set bit searching cyclically from cur_ch+1.
  - Register the selection into cur_ch and go to GRANT on the next edge.
  - s_ready=0 in IDLE, so each frame costs one bubble cycle.
- GRANT:
  - s_ready[cur_ch]=1; all other s_ready=0.
  - Beat accepted = s_valid[cur_ch] & s_ready[cur_ch].
  - Each accepted beat is registered to the m_* outputs with exactly 1-cycle latency; m_valid=1 for exactly that cycle, and 0 in any cycle with no accepted beat.
  - m_user = {cur_ch, s_user[cur_ch]}.
  - The beat counter increments per accepted beat and resets to 0 on frame end.
- GRANT exits:
  - Accepted beat with s_last=1: m_last=1, go to IDLE.
  - Otherwise, accepted beat that is beat number max_len (counter==max_len-1) with max_len≠0: force m_last=1, set trunc_err[cur_ch], go to DRAIN.
  - If s_last and the limit coincide on the same beat: normal end, no error.
- DRAIN:
  - s_ready[cur_ch]=1; beats are consumed and discarded; m_valid=0.
  - Accepted beat with s_last=1 → IDLE.
- A source holding valid low mid-frame just stalls the grant; there is no timeout.
- ch_enable and max_len:
  - ch_enable changes affect arbitration only; a frame in progress on a channel that becomes disabled completes normally.
  - max_len is sampled per beat. Lowering it below the current count truncates on the next accepted beat.
- trunc_err clearing: err_clr clears its bits in the cycle after assertion. A set event in the same cycle as a clear on the same bit wins (bit stays 1).
- busy = (state≠IDLE).
- Throughput: one beat per cycle inside a frame; the downstream pipeline has no ready, so m_* is never stalled.
- Return-path routing uses o_user[USER_WIDTH +: CH_BITS]; demux is external to this block.

Test Plan:
- Single channel 0, 8-beat frame with max_len=0 → grant 1 cycle after valid; m_valid for 8 consecutive cycles; m_last on beat 8; m_user[top]=0; back to IDLE.
- Ch1 and ch3 both continuously valid, 4-beat frames, cur_ch=0 → frame order 1,3,1,3; each frame contiguous, never interleaved; 1 idle cycle between frames.
- max_len=5, ch2 sends a 9-beat frame → 5 m_valid beats with m_last on beat 5; beats 6–9 consumed with m_valid=0; trunc_err=4'b0100; err_clr=4'b0100 → 0.
- ch_enable=4'b1110 with ch0 valid only → no grant, s_ready=0, busy=0; then enable bit0 → grant within 2 cycles.
- ch0 drops valid for 3 cycles mid-frame → m_valid gaps of exactly 3 cycles; no re-arbitration; ch1 requests are ignored until ch0's last.
- rst pulsed during beat 3 of a ch1 frame → next cycle all outputs at reset values; the first grant after reset goes to the lowest valid enabled channel starting from ch0.
